// File: rtl/mem_pkg.sv
// Shared definitions for the MEM stage: funct3 size/sign codes and the bus FSM states.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, BUS, DONE} mem_state_t;

endpackage

// File: rtl/load_align.sv
// Picks the addressed byte/halfword out of a bus word and sign- or zero-extends it.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] i_wb_dat,
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  output logic [31:0] o_data
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_shifted = i_wb_dat >> {i_addr_lo, 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = i_addr_lo[1] ? i_wb_dat[31:16] : i_wb_dat[15:0];

  always_comb begin
    o_data = i_wb_dat;
    case (i_funct3)
      F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_data = {24'h000000, w_byte};
      F3_H:    o_data = {{16{w_half[15]}}, w_half};
      F3_HU:   o_data = {16'h0000, w_half};
      default: o_data = i_wb_dat;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: one Wishbone classic cycle per load/store, stalling the pipe while busy.
module mem_access_stage
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] store_data_in,
  output logic [DATA_WIDTH-1:0] load_data_out,
  output logic                  mem_busy,
  output logic                  misaligned,
  output logic                  wb_cyc_o,
  output logic                  wb_stb_o,
  output logic                  wb_we_o,
  output logic [ADDR_WIDTH-1:0] wb_adr_o,
  output logic [DATA_WIDTH-1:0] wb_dat_o,
  output logic [3:0]            wb_sel_o,
  input  logic [DATA_WIDTH-1:0] wb_dat_i,
  input  logic                  wb_ack_i
);

  mem_state_t            r_state, w_state_next;
  logic                  r_cyc, r_we;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0] r_dat, r_load;
  logic [3:0]            r_sel;
  logic [2:0]            r_f3;
  logic [1:0]            r_alo;

  logic                  w_access, w_misaligned, w_req;
  logic [3:0]            w_sel;
  logic [DATA_WIDTH-1:0] w_sdat, w_ext;

  assign w_access = mem_read | mem_write;

  always_comb begin
    w_misaligned = 1'b0;
    case (funct3)
      F3_H, F3_HU: w_misaligned = addr_in[0];
      F3_W:        w_misaligned = |addr_in[1:0];
      default:     w_misaligned = 1'b0;
    endcase
    w_misaligned = w_misaligned & w_access;
  end

  assign w_req = w_access & ~w_misaligned;

  // Store lanes; BU/HU share the B/H lane pattern so loads latch a meaningful sel.
  always_comb begin
    w_sel  = 4'b1111;
    w_sdat = store_data_in;
    case (funct3)
      F3_B, F3_BU: begin
        w_sel  = 4'b0001 << addr_in[1:0];
        w_sdat = {4{store_data_in[7:0]}};
      end
      F3_H, F3_HU: begin
        w_sel  = 4'b0011 << {addr_in[1], 1'b0};
        w_sdat = {2{store_data_in[15:0]}};
      end
      default: begin
        w_sel  = 4'b1111;
        w_sdat = store_data_in;
      end
    endcase
  end

  load_align u_load_align (
    .i_wb_dat  (wb_dat_i),
    .i_funct3  (r_f3),
    .i_addr_lo (r_alo),
    .o_data    (w_ext)
  );

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_req) w_state_next = BUS;
      BUS:     if (wb_ack_i) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cyc  <= 1'b0;
      r_we   <= 1'b0;
      r_adr  <= '0;
      r_dat  <= '0;
      r_sel  <= 4'b0000;
      r_load <= '0;
      r_f3   <= 3'b000;
      r_alo  <= 2'b00;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_cyc <= 1'b1;
            r_we  <= mem_write;
            r_adr <= {addr_in[ADDR_WIDTH-1:2], 2'b00};
            r_dat <= w_sdat;
            r_sel <= w_sel;
            r_f3  <= funct3;
            r_alo <= addr_in[1:0];
          end else if (w_misaligned) begin
            r_load <= '0;
          end
        end
        BUS: begin
          if (wb_ack_i) begin
            r_cyc <= 1'b0;
            if (!r_we) r_load <= w_ext;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_busy      = ((r_state == IDLE) & w_req) | (r_state == BUS);
  assign misaligned    = w_misaligned;
  assign wb_cyc_o      = r_cyc;
  assign wb_stb_o      = r_cyc;
  assign wb_we_o       = r_we;
  assign wb_adr_o      = r_adr;
  assign wb_dat_o      = r_dat;
  assign wb_sel_o      = r_sel;
  assign load_data_out = r_load;

endmodule
